// File: rtl/d3_28_ucode_pkg.sv
// Shared constants, command codes and loader state encoding for the
// microcode control-store loader.
package d3_28_ucode_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 44;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_END   = 8'h5A;

  // word_count saturates at the full store size (4096 words)
  localparam logic [CNT_W-1:0] WORD_MAX = CNT_W'(1 << ADDR_W);

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR_H,
    ADDR_L,
    DATA,
    CHK,
    WRITE,
    READ,
    VERIFY,
    DONE,
    ERROR
  } state_e;

  // Control store write payload held for the write/readback sequence
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cs_word_t;

endpackage

// File: rtl/ucode_frame_rx.sv
// Frame assembler: byte counter, address/data capture and running XOR checksum.
// frame_ok / frame_bad are qualified by chk_fire and valid in that cycle only.
import d3_28_ucode_pkg::*;

module ucode_frame_rx (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              cmd_fire,
  input  logic              addr_h_fire,
  input  logic              addr_l_fire,
  input  logic              data_fire,
  input  logic              chk_fire,
  output logic              data_last,
  output logic              frame_ok,
  output logic              frame_bad,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);

  logic [2:0]        cnt;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;

  // A write command restarts the counter and seeds the checksum with itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 3'd0;
      csum   <= 8'd0;
      addr_q <= '0;
      word_q <= '0;
    end else begin
      if (cmd_fire) begin
        cnt  <= 3'd0;
        csum <= byte_in;
      end
      if (addr_h_fire) begin
        addr_q[ADDR_W-1:8] <= byte_in[3:0];
        csum               <= csum ^ byte_in;
      end
      if (addr_l_fire) begin
        addr_q[7:0] <= byte_in;
        csum        <= csum ^ byte_in;
      end
      if (data_fire) begin
        if (cnt == 3'd5) word_q[DATA_W-1:40] <= byte_in[3:0];
        else             word_q[{cnt, 3'b000} +: 8] <= byte_in;
        cnt  <= cnt + 3'd1;
        csum <= csum ^ byte_in;
      end
    end
  end

  assign data_last = (cnt == 3'd5);
  assign frame_ok  = chk_fire && (csum == byte_in);
  assign frame_bad = chk_fire && (csum != byte_in);
  assign addr      = addr_q;
  assign word      = word_q;

endmodule

// File: rtl/microcode_loader.sv
// Control-store loader: session FSM, write/readback strobes, sticky status flags.
// All outputs are registered from the next-state decode so they align with the state.
import d3_28_ucode_pkg::*;

module microcode_loader (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] cs_addr,
  output logic [DATA_W-1:0] cs_wdata,
  output logic              cs_we,
  output logic              cs_re,
  input  logic [DATA_W-1:0] cs_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err_chk,
  output logic              err_verify,
  output logic              err_frame,
  output logic [ADDR_W:0]   word_count
);

  state_e            state_q, state_d;
  cs_word_t          cs_q;
  logic              rx_ready_q, cs_we_q, cs_re_q, hold_q;
  logic              done_q, err_chk_q, err_verify_q, err_frame_q;
  logic [CNT_W-1:0]  count_q;

  logic              rx_fire, cmd_fire, addr_h_fire, addr_l_fire, data_fire, chk_fire;
  logic              data_last, frame_ok, frame_bad, verify_ok;
  logic [ADDR_W-1:0] fr_addr;
  logic [DATA_W-1:0] fr_word;

  assign rx_fire     = rx_valid && rx_ready_q;
  assign cmd_fire    = rx_fire && (state_q == CMD) && (rx_data == CMD_WRITE);
  assign addr_h_fire = rx_fire && (state_q == ADDR_H);
  assign addr_l_fire = rx_fire && (state_q == ADDR_L);
  assign data_fire   = rx_fire && (state_q == DATA);
  assign chk_fire    = rx_fire && (state_q == CHK);
  assign verify_ok   = (cs_rdata == cs_q.data);

  ucode_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (rx_data),
    .cmd_fire   (cmd_fire),
    .addr_h_fire(addr_h_fire),
    .addr_l_fire(addr_l_fire),
    .data_fire  (data_fire),
    .chk_fire   (chk_fire),
    .data_last  (data_last),
    .frame_ok   (frame_ok),
    .frame_bad  (frame_bad),
    .addr       (fr_addr),
    .word       (fr_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Dropping load_req abandons a frame still being received; once the write
  // has started the readback is completed before returning to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (load_req) state_d = CMD;
      CMD: begin
        if (!load_req) state_d = IDLE;
        else if (rx_fire) begin
          if (rx_data == CMD_WRITE)    state_d = ADDR_H;
          else if (rx_data == CMD_END) state_d = DONE;
          else                         state_d = ERROR;
        end
      end
      ADDR_H: begin
        if (!load_req)    state_d = IDLE;
        else if (rx_fire) state_d = ADDR_L;
      end
      ADDR_L: begin
        if (!load_req)    state_d = IDLE;
        else if (rx_fire) state_d = DATA;
      end
      DATA: begin
        if (!load_req)                  state_d = IDLE;
        else if (rx_fire && data_last)  state_d = CHK;
      end
      CHK: begin
        if (!load_req)      state_d = IDLE;
        else if (frame_ok)  state_d = WRITE;
        else if (frame_bad) state_d = ERROR;
      end
      WRITE:  state_d = READ;
      READ:   state_d = VERIFY;
      VERIFY: begin
        if (!verify_ok)    state_d = ERROR;
        else if (load_req) state_d = CMD;
        else               state_d = IDLE;
      end
      DONE, ERROR: if (!load_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers, payload latch and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q   <= 1'b0;
      cs_we_q      <= 1'b0;
      cs_re_q      <= 1'b0;
      hold_q       <= 1'b0;
      cs_q         <= '0;
      done_q       <= 1'b0;
      err_chk_q    <= 1'b0;
      err_verify_q <= 1'b0;
      err_frame_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      rx_ready_q <= (state_d inside {CMD, ADDR_H, ADDR_L, DATA, CHK});
      cs_we_q    <= (state_d == WRITE);
      cs_re_q    <= (state_d == READ);
      hold_q     <= (state_d != IDLE);
      if ((state_q == CHK) && (state_d == WRITE)) begin
        cs_q.addr <= fr_addr;
        cs_q.data <= fr_word;
      end
      if ((state_q == IDLE) && (state_d == CMD)) begin
        done_q       <= 1'b0;
        err_chk_q    <= 1'b0;
        err_verify_q <= 1'b0;
        err_frame_q  <= 1'b0;
        count_q      <= '0;
      end else begin
        if ((state_q == CMD) && (state_d == DONE))    done_q       <= 1'b1;
        if ((state_q == DONE) && (state_d == IDLE))   done_q       <= 1'b0;
        if ((state_q == CMD) && (state_d == ERROR))   err_frame_q  <= 1'b1;
        if ((state_q == CHK) && (state_d == ERROR))   err_chk_q    <= 1'b1;
        if ((state_q == VERIFY) && (state_d == ERROR)) err_verify_q <= 1'b1;
        if ((state_q == VERIFY) && verify_ok && (count_q != WORD_MAX))
          count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign cs_addr    = cs_q.addr;
  assign cs_wdata   = cs_q.data;
  assign cs_we      = cs_we_q;
  assign cs_re      = cs_re_q;
  assign cpu_hold   = hold_q;
  assign busy       = hold_q;
  assign done       = done_q;
  assign err_chk    = err_chk_q;
  assign err_verify = err_verify_q;
  assign err_frame  = err_frame_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_microcode_loader.sv
// Directed self-checking bench for microcode_loader with a behavioural control-store RAM.
module tb_microcode_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] cs_addr;
  logic [43:0] cs_wdata;
  logic        cs_we;
  logic        cs_re;
  logic [43:0] cs_rdata = '0;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err_chk;
  logic        err_verify;
  logic        err_frame;
  logic [12:0] word_count;

  logic [43:0] ram [4096] = '{default: '0};
  logic [43:0] flip = '0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [11:0] last_we_addr = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          we0;
  int          re0;

  always #5 clk = ~clk;

  microcode_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cs_addr   (cs_addr),
    .cs_wdata  (cs_wdata),
    .cs_we     (cs_we),
    .cs_re     (cs_re),
    .cs_rdata  (cs_rdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err_chk   (err_chk),
    .err_verify(err_verify),
    .err_frame (err_frame),
    .word_count(word_count)
  );

  // Control store: synchronous write, registered read with optional bit corruption
  always @(posedge clk) begin
    if (cs_we) begin
      ram[cs_addr] <= cs_wdata;
      last_we_addr <= cs_addr;
      we_cnt = we_cnt + 1;
    end
    if (cs_re) begin
      cs_rdata <= ram[cs_addr] ^ flip;
      re_cnt = re_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b", b, rx_ready);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  // Upper nibbles of addr_hi and d5 carry junk that the loader must ignore
  task automatic send_frame(input logic [11:0] a, input logic [43:0] d, input logic [7:0] corrupt);
    logic [7:0] b [9];
    logic [7:0] chk;
    b[0] = 8'hA5;
    b[1] = {4'hE, a[11:8]};
    b[2] = a[7:0];
    b[3] = d[7:0];
    b[4] = d[15:8];
    b[5] = d[23:16];
    b[6] = d[31:24];
    b[7] = d[39:32];
    b[8] = {4'h9, d[43:40]};
    chk = 8'h00;
    for (int i = 0; i < 9; i++) chk = chk ^ b[i];
    for (int i = 0; i < 9; i++) send_byte(b[i]);
    send_byte(chk ^ corrupt);
  endtask

  task automatic test_reset;
    tick(1);
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    n_cmp++; if ({cs_we, cs_re} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {cs_we, cs_re}); end
    n_cmp++; if ({done, err_chk, err_verify, err_frame} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {done, err_chk, err_verify, err_frame}); end
    n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    n_cmp++; if ({cs_addr, cs_wdata} !== 56'd0) begin n_bad++; $display("FAIL reset_cs_bus: got %h/%h want 0", cs_addr, cs_wdata); end
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL idle_cpu_hold: got %b want 0", cpu_hold); end
  endtask

  task automatic test_write;
    load_req = 1'b1;
    tick(1);
    n_cmp++; if ({cpu_hold, busy, rx_ready} !== 3'b111) begin n_bad++; $display("FAIL session_start: hold/busy/ready got %b want 111", {cpu_hold, busy, rx_ready}); end
    we0 = we_cnt; re0 = re_cnt;
    send_frame(12'h3C1, 44'h0AB_CDEF_1234, 8'h00);
    n_cmp++; if ({cs_we, cs_addr, cs_wdata} !== {1'b1, 12'h3C1, 44'h0AB_CDEF_1234}) begin n_bad++; $display("FAIL write_strobe: we/addr/data got %b/%h/%h want 1/3c1/0abcdef1234", cs_we, cs_addr, cs_wdata); end
    tick(4);
    n_cmp++; if (we_cnt - we0 !== 1) begin n_bad++; $display("FAIL write_we_count: got %0d want 1", we_cnt - we0); end
    n_cmp++; if (re_cnt - re0 !== 1) begin n_bad++; $display("FAIL write_re_count: got %0d want 1", re_cnt - re0); end
    n_cmp++; if (last_we_addr !== 12'h3C1) begin n_bad++; $display("FAIL write_addr: got %h want 3c1", last_we_addr); end
    n_cmp++; if (ram[12'h3C1] !== 44'h0AB_CDEF_1234) begin n_bad++; $display("FAIL write_ram: got %h want 0abcdef1234", ram[12'h3C1]); end
    n_cmp++; if (word_count !== 13'd1) begin n_bad++; $display("FAIL write_word_count: got %0d want 1", word_count); end
    n_cmp++; if ({err_chk, err_verify, err_frame, rx_ready} !== 4'b0001) begin n_bad++; $display("FAIL write_flags: chk/ver/frm/ready got %b want 0001", {err_chk, err_verify, err_frame, rx_ready}); end
  endtask

  task automatic test_bad_chk;
    we0 = we_cnt;
    send_frame(12'h100, 44'h123_4567_89AB, 8'h01);
    tick(4);
    n_cmp++; if (err_chk !== 1'b1) begin n_bad++; $display("FAIL chk_err_flag: got %b want 1", err_chk); end
    n_cmp++; if (we_cnt - we0 !== 0) begin n_bad++; $display("FAIL chk_no_write: got %0d writes want 0", we_cnt - we0); end
    n_cmp++; if (ram[12'h100] !== 44'd0) begin n_bad++; $display("FAIL chk_ram: got %h want 0", ram[12'h100]); end
    n_cmp++; if ({cpu_hold, word_count} !== {1'b1, 13'd1}) begin n_bad++; $display("FAIL chk_hold_count: got %b/%0d want 1/1", cpu_hold, word_count); end
    load_req = 1'b0;
    tick(2);
    n_cmp++; if ({cpu_hold, err_chk} !== 2'b01) begin n_bad++; $display("FAIL chk_exit: hold/err got %b want 01", {cpu_hold, err_chk}); end
  endtask

  task automatic test_verify_err;
    load_req = 1'b1;
    tick(1);
    n_cmp++; if ({err_chk, word_count} !== 14'd0) begin n_bad++; $display("FAIL new_session_clear: err_chk/count got %b/%0d want 0/0", err_chk, word_count); end
    flip = 44'h000_0001_0000;
    we0 = we_cnt;
    send_frame(12'h0FF, 44'hFFF_0000_FFFF, 8'h00);
    tick(4);
    n_cmp++; if (err_verify !== 1'b1) begin n_bad++; $display("FAIL verify_err_flag: got %b want 1", err_verify); end
    n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL verify_word_count: got %0d want 0", word_count); end
    n_cmp++; if (we_cnt - we0 !== 1) begin n_bad++; $display("FAIL verify_write_done: got %0d want 1", we_cnt - we0); end
    tick(5);
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL verify_hold: got %b want 1", cpu_hold); end
    load_req = 1'b0;
    flip = '0;
    tick(2);
    n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL verify_release: got %b want 0", cpu_hold); end
  endtask

  task automatic test_bad_cmd;
    load_req = 1'b1;
    tick(1);
    send_byte(8'h33);
    n_cmp++; if ({err_frame, err_verify} !== 2'b10) begin n_bad++; $display("FAIL frame_err: frame/verify got %b want 10", {err_frame, err_verify}); end
    load_req = 1'b0;
    tick(1);
    n_cmp++; if ({cpu_hold, busy} !== 2'b00) begin n_bad++; $display("FAIL frame_release: got %b want 00", {cpu_hold, busy}); end
  endtask

  task automatic test_back_to_back;
    load_req = 1'b1;
    tick(1);
    we0 = we_cnt;
    send_frame(12'h010, 44'h111_2222_3333, 8'h00);
    send_frame(12'hFFF, 44'hFFF_FFFF_FFFF, 8'h00);
    send_frame(12'h010, 44'h000_0000_0001, 8'h00);
    send_byte(8'h5A);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", done); end
    n_cmp++; if (word_count !== 13'd3) begin n_bad++; $display("FAIL b2b_word_count: got %0d want 3", word_count); end
    n_cmp++; if (we_cnt - we0 !== 3) begin n_bad++; $display("FAIL b2b_writes: got %0d want 3", we_cnt - we0); end
    n_cmp++; if (ram[12'h010] !== 44'h000_0000_0001) begin n_bad++; $display("FAIL b2b_last_wins: got %h want 00000000001", ram[12'h010]); end
    n_cmp++; if (ram[12'hFFF] !== 44'hFFF_FFFF_FFFF) begin n_bad++; $display("FAIL b2b_top_addr: got %h want fffffffffff", ram[12'hFFF]); end
    n_cmp++; if ({err_chk, err_verify, err_frame, cpu_hold} !== 4'b0001) begin n_bad++; $display("FAIL b2b_flags: got %b want 0001", {err_chk, err_verify, err_frame, cpu_hold}); end
    load_req = 1'b0;
    tick(1);
    load_req = 1'b1;
    tick(1);
    n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL b2b_count_clear: got %0d want 0", word_count); end
  endtask

  task automatic test_abort;
    we0 = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    load_req = 1'b0;
    tick(1);
    n_cmp++; if ({cpu_hold, busy, rx_ready} !== 3'b000) begin n_bad++; $display("FAIL abort_idle: hold/busy/ready got %b want 000", {cpu_hold, busy, rx_ready}); end
    tick(4);
    n_cmp++; if (we_cnt - we0 !== 0) begin n_bad++; $display("FAIL abort_no_write: got %0d want 0", we_cnt - we0); end
  endtask

  task automatic test_reset_in_write;
    load_req = 1'b1;
    tick(1);
    send_frame(12'h2AA, 44'h555_5555_5555, 8'h00);
    n_cmp++; if (cs_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we: got %b want 1", cs_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs_we !== 1'b0) begin n_bad++; $display("FAIL rst_async_we: got %b want 0", cs_we); end
    n_cmp++; if ({cs_addr, cs_wdata} !== 56'd0) begin n_bad++; $display("FAIL rst_async_bus: got %h/%h want 0", cs_addr, cs_wdata); end
    n_cmp++; if ({cpu_hold, busy, rx_ready, cs_re} !== 4'b0000) begin n_bad++; $display("FAIL rst_async_ctrl: got %b want 0000", {cpu_hold, busy, rx_ready, cs_re}); end
    load_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if ({cpu_hold, word_count} !== 14'd0) begin n_bad++; $display("FAIL rst_after: got %b/%0d want 0/0", cpu_hold, word_count); end
  endtask

  initial begin
    rst_n    = 1'b0;
    load_req = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    test_reset();
    test_write();
    test_bad_chk();
    test_verify_err();
    test_bad_cmd();
    test_back_to_back();
    test_abort();
    test_reset_in_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
